// File: rtl/monitor_event_scheduler.sv
// rtl/monitor_event_scheduler.sv - event FIFO and paced issue sequencer feeding the RTLola monitor
// Buffers events and issues them as one-cycle strobes at least EVAL_GAP cycles apart.
module monitor_event_scheduler #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int EVAL_GAP   = 2,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_mask,
  input  logic [DATA_W-1:0]             in_data_0,
  input  logic [DATA_W-1:0]             in_data_1,
  output logic [DATA_W-1:0]             input_0,
  output logic                          new_input_0,
  output logic [DATA_W-1:0]             input_1,
  output logic                          new_input_1,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              issued_count,
  output logic [CNT_W-1:0]              dropped_count
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = AW + 1;
  localparam int GAP_LOAD = (EVAL_GAP >= 2) ? EVAL_GAP - 2 : 0;
  localparam int GAP_W    = (GAP_LOAD > 1) ? $clog2(GAP_LOAD + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t             r_state, w_state_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
  logic               w_issue;

  logic [1:0]         r_mem_mask [FIFO_DEPTH];
  logic [DATA_W-1:0]  r_mem_d0   [FIFO_DEPTH];
  logic [DATA_W-1:0]  r_mem_d1   [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]   r_level;

  logic [1:0]         r_strobe;
  logic [DATA_W-1:0]  r_data_0, r_data_1;
  logic [CNT_W-1:0]   r_issued, r_dropped;

  logic               w_full, w_empty, w_accept, w_push, w_drop;
  logic [1:0]         w_head_mask;
  logic [DATA_W-1:0]  w_head_d0, w_head_d1;

  assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty     = (r_level == '0);
  // Gated by rst so the handshake is closed while reset is asserted.
  assign in_ready    = rst & en & ~w_full;
  assign w_accept    = in_valid & in_ready;
  assign w_push      = w_accept & (|in_mask);
  assign w_drop      = w_accept & ~(|in_mask);
  assign w_head_mask = r_mem_mask[r_rd_ptr];
  assign w_head_d0   = r_mem_d0[r_rd_ptr];
  assign w_head_d1   = r_mem_d1[r_rd_ptr];

  // w_issue marks the edge that enters ISSUE: pop, load data and raise strobes together.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_issue     = 1'b0;
    if (en) begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            w_state_nxt = S_ISSUE;
            w_issue     = 1'b1;
          end
        end
        S_ISSUE: begin
          if (EVAL_GAP == 1) begin
            if (!w_empty) begin
              w_state_nxt = S_ISSUE;
              w_issue     = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = GAP_W'(GAP_LOAD);
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            if (!w_empty) begin
              w_state_nxt = S_ISSUE;
              w_issue     = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_gap_nxt = r_gap_cnt - GAP_W'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_mask[r_wr_ptr] <= in_mask;
      r_mem_d0[r_wr_ptr]   <= in_data_0;
      r_mem_d1[r_wr_ptr]   <= in_data_1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_issue})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Strobes hold through en=0 and are masked at the port, so a frozen ISSUE
  // still delivers its event exactly once while the monitor is enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_strobe  <= 2'b00;
      r_data_0  <= '0;
      r_data_1  <= '0;
      r_issued  <= '0;
      r_dropped <= '0;
    end else begin
      if (en) r_strobe <= w_issue ? w_head_mask : 2'b00;
      if (w_issue) begin
        if (w_head_mask[0]) r_data_0 <= w_head_d0;
        if (w_head_mask[1]) r_data_1 <= w_head_d1;
        r_issued <= r_issued + CNT_W'(1);
      end
      if (w_drop) r_dropped <= r_dropped + CNT_W'(1);
    end
  end

  assign new_input_0   = r_strobe[0] & en;
  assign new_input_1   = r_strobe[1] & en;
  assign input_0       = r_data_0;
  assign input_1       = r_data_1;
  assign busy          = (r_state != S_IDLE) | ~w_empty;
  assign fifo_level    = r_level;
  assign issued_count  = r_issued;
  assign dropped_count = r_dropped;

endmodule

// File: tb/tb_monitor_event_scheduler.sv
// tb/tb_monitor_event_scheduler.sv - bench for monitor_event_scheduler
// Two instances (EVAL_GAP 2 and 8) share stimulus; each is checked against a spacing-rule model.
module tb_monitor_event_scheduler;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_mask = 2'b00;
  logic [DW-1:0] d0 = '0;
  logic [DW-1:0] d1 = '0;

  logic [1:0]          w_rdy, w_n0, w_n1, w_busy;
  logic [1:0][DW-1:0]  w_i0, w_i1;
  logic [1:0][2:0]     w_lvl;
  logic [1:0][15:0]    w_iss, w_drp;

  int n_checks = 0;
  int n_errors = 0;

  monitor_event_scheduler #(.DATA_W(DW), .FIFO_DEPTH(4), .EVAL_GAP(2), .CNT_W(16)) u_gap2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(w_rdy[0]),
    .in_mask(in_mask), .in_data_0(d0), .in_data_1(d1),
    .input_0(w_i0[0]), .new_input_0(w_n0[0]), .input_1(w_i1[0]), .new_input_1(w_n1[0]),
    .busy(w_busy[0]), .fifo_level(w_lvl[0]), .issued_count(w_iss[0]), .dropped_count(w_drp[0])
  );

  monitor_event_scheduler #(.DATA_W(DW), .FIFO_DEPTH(4), .EVAL_GAP(8), .CNT_W(16)) u_gap8 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(w_rdy[1]),
    .in_mask(in_mask), .in_data_0(d0), .in_data_1(d1),
    .input_0(w_i0[1]), .new_input_0(w_n0[1]), .input_1(w_i1[1]), .new_input_1(w_n1[1]),
    .busy(w_busy[1]), .fifo_level(w_lvl[1]), .issued_count(w_iss[1]), .dropped_count(w_drp[1])
  );

  always #5 clk = ~clk;

  // Model: a queue plus "enabled edges since last issue"; an issue happens on an
  // enabled edge when the queue is non-empty and at least EVAL_GAP edges have passed.
  typedef struct {
    logic [1:0]    m;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } ev_t;

  ev_t           mq [2][4];
  int            mcnt [2];
  int            ms [2];
  int            mgap [2];
  logic [1:0]    mstb [2];
  logic [DW-1:0] md0 [2];
  logic [DW-1:0] md1 [2];
  int            miss [2];
  int            mdrp [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mgap[0] = 2;
    mgap[1] = 8;
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      ms[k]   = mgap[k];
      mstb[k] = 2'b00;
      md0[k]  = '0;
      md1[k]  = '0;
      miss[k] = 0;
      mdrp[k] = 0;
    end
  endtask

  function automatic logic m_rdy(input int k);
    return rst & en & (mcnt[k] < 4);
  endfunction

  task automatic model_edge();
    bit acc;
    int ns;
    ev_t e;
    if (rst && en) begin
      for (int k = 0; k < 2; k++) begin
        acc = in_valid && m_rdy(k);
        ns  = (ms[k] + 1 > mgap[k]) ? mgap[k] : ms[k] + 1;
        if (mcnt[k] > 0 && ns >= mgap[k]) begin
          e = mq[k][0];
          for (int j = 0; j < 3; j++) mq[k][j] = mq[k][j+1];
          mcnt[k]--;
          mstb[k] = e.m;
          if (e.m[0]) md0[k] = e.a;
          if (e.m[1]) md1[k] = e.b;
          miss[k]++;
          ms[k] = 0;
        end else begin
          mstb[k] = 2'b00;
          ms[k]   = ns;
        end
        if (acc) begin
          if (in_mask == 2'b00) mdrp[k]++;
          else begin
            mq[k][mcnt[k]].m = in_mask;
            mq[k][mcnt[k]].a = d0;
            mq[k][mcnt[k]].b = d1;
            mcnt[k]++;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.g%0d.in_ready", tag, mgap[k]), w_rdy[k], m_rdy(k));
      chk($sformatf("%s.g%0d.new_input_0", tag, mgap[k]), w_n0[k], mstb[k][0] & en & rst);
      chk($sformatf("%s.g%0d.new_input_1", tag, mgap[k]), w_n1[k], mstb[k][1] & en & rst);
      chk($sformatf("%s.g%0d.input_0", tag, mgap[k]), w_i0[k], md0[k]);
      chk($sformatf("%s.g%0d.input_1", tag, mgap[k]), w_i1[k], md1[k]);
      chk($sformatf("%s.g%0d.fifo_level", tag, mgap[k]), w_lvl[k], mcnt[k]);
      chk($sformatf("%s.g%0d.busy", tag, mgap[k]), w_busy[k], (ms[k] < mgap[k]) || (mcnt[k] != 0));
      chk($sformatf("%s.g%0d.issued", tag, mgap[k]), w_iss[k], miss[k] & 16'hffff);
      chk($sformatf("%s.g%0d.dropped", tag, mgap[k]), w_drp[k], mdrp[k] & 16'hffff);
    end
  endtask

  task automatic cycle(input bit e, input bit v, input logic [1:0] m,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    en = e; in_valid = v; in_mask = m; d0 = a; d1 = b;
    #1;
    check_all("cyc");
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b1, 1'b0, 2'b00, '0, '0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; in_valid = 1'b0;
    #1;
    check_all("rst_release");
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    release_reset();
  endtask

  initial begin
    bit took;
    model_reset();
    rst = 1'b0; en = 1'b1; in_valid = 1'b1; in_mask = 2'b11;
    d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
    #2;
    check_all("reset");
    chk("reset_in_ready", w_rdy[0], 1'b0);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; in_valid = 1'b0;
    #1;
    chk("post_reset_in_ready", w_rdy[0], 1'b1);
    @(posedge clk);
    model_edge();

    cycle(1'b1, 1'b1, 2'b11, 64'd1, 64'd1);
    cycle(1'b1, 1'b0, 2'b00, '0, '0);
    #3;
    chk("single_strobe", {w_n1[0], w_n0[0]}, 2'b11);
    chk("single_input_0", w_i0[0], 64'd1);
    chk("single_issued", w_iss[0], 16'd1);
    idle(12);

    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 2'b11, DW'(i), DW'(i));
    idle(40);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int t = 0; t < 40; t++) begin
        took = (mcnt[1] < 4);
        cycle(1'b1, 1'b1, 2'b11, DW'(100 + i), DW'(200 + i));
        if (took) break;
      end
    end
    idle(70);
    chk("full_issued_g8", w_iss[1], 16'd6);
    chk("full_last_data_g8", w_i1[1], 64'd205);

    do_reset();
    cycle(1'b1, 1'b1, 2'b01, 64'd7, 64'd9);
    idle(12);
    chk("mask01_input_1", w_i1[0], 64'd0);
    cycle(1'b1, 1'b1, 2'b10, 64'd0, 64'd5);
    idle(12);
    chk("mask10_input_0", w_i0[0], 64'd7);
    chk("mask10_input_1", w_i1[0], 64'd5);
    cycle(1'b1, 1'b1, 2'b00, 64'd3, 64'd3);
    idle(4);
    chk("mask00_dropped", w_drp[0], 16'd1);
    chk("mask00_issued", w_iss[0], 16'd2);

    do_reset();
    cycle(1'b1, 1'b1, 2'b11, 64'd5, 64'd6);
    cycle(1'b1, 1'b1, 2'b11, 64'd7, 64'd8);
    idle(3);
    repeat (6) cycle(1'b0, 1'b1, 2'b11, 64'd9, 64'd9);
    idle(30);
    chk("en_gap_issued_g8", w_iss[1], 16'd2);

    cycle(1'b1, 1'b1, 2'b11, 64'd11, 64'd12);
    cycle(1'b1, 1'b1, 2'b11, 64'd13, 64'd14);
    for (int t = 0; t < 10 && mstb[0] == 2'b00; t++) idle(1);
    chk("rst_mid_reached_issue", mstb[0] != 2'b00, 1'b1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("rst_mid");
    chk("rst_mid_strobes", {w_n1[0], w_n0[0]}, 2'b00);
    chk("rst_mid_level", w_lvl[0], 3'd0);
    release_reset();

    repeat (600) begin
      cycle(($urandom % 8) != 0, $urandom % 2, 2'($urandom % 4),
            {$urandom, $urandom}, {$urandom, $urandom});
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
